uart_rx_core: RTL

//   Serial receive front end placed directly upstream of uart_dev's receive buffer.

---
 rtl/uart_rx_core_pkg.sv | 20 ++
 rtl/uart_rx_fifo.sv | 64 ++++++
 rtl/uart_rx_core.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_core_pkg.sv
// Shared definitions for the UART receive path.
// State codes, default bit timing and the 3-sample vote.
package uart_rx_core_pkg;

    localparam int DEF_CLKS_PER_BIT = 48;

    // Consecutive high samples (minus one) needed to leave WAIT_IDLE.
    localparam int IDLE_SETTLE = 3;

    localparam logic [2:0] WAIT_IDLE = 3'd0;
    localparam logic [2:0] IDLE      = 3'd1;
    localparam logic [2:0] START     = 3'd2;
    localparam logic [2:0] DATA      = 3'd3;
    localparam logic [2:0] STOP      = 3'd4;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO.
// A push into a full FIFO is dropped unless a pop frees a slot that cycle.
module uart_rx_fifo
    import uart_rx_core_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    wdata,
    input  logic          pop,
    output logic [7:0]    rdata,
    output logic          valid,
    output logic [AW:0]   count,
    output logic          full,
    output logic          dropped
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign valid   = (count != '0);
    assign full    = (count == FULL_CNT);
    assign pop_ok  = pop & valid;
    assign push_ok = push & (~full | pop_ok);
    assign dropped = push & ~push_ok;
    assign rdata   = valid ? mem[rd_ptr] : 8'h00;

    // Storage write; contents only matter while counted.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy; pointers wrap at DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART 8N1 receiver: synchroniser, 3-sample voting, framing FSM,
// sticky error flags and a small show-ahead FIFO toward the consumer.
module uart_rx_core
    import uart_rx_core_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4,
    parameter int FIFO_AW      = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               uart_rxd,
    output logic [7:0]         rx_data,
    output logic               rx_valid,
    input  logic               rx_ready,
    output logic [FIFO_AW:0]   rx_count,
    output logic               frame_err,
    output logic               overrun,
    input  logic               err_clr
);

    localparam int H  = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);

    // Start bit is voted around its centre (H-1..H+1). Once it is
    // accepted the counter restarts, so every later bit is voted on the
    // last three counts of its period, one full bit after the previous.
    localparam logic [CW-1:0] C_HM1    = CW'(H - 1);
    localparam logic [CW-1:0] C_H      = CW'(H);
    localparam logic [CW-1:0] C_HP1    = CW'(H + 1);
    localparam logic [CW-1:0] C_E2     = CW'(CLKS_PER_BIT - 3);
    localparam logic [CW-1:0] C_E1     = CW'(CLKS_PER_BIT - 2);
    localparam logic [CW-1:0] C_E0     = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_SETTLE = CW'(IDLE_SETTLE);

    logic          rxd_m;
    logic          rxd_s;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          s0;
    logic          s1;
    logic          in_bit;
    logic          at_s0;
    logic          at_s1;
    logic          at_dec;
    logic          maj;
    logic          push_byte;
    logic          stop_bad;
    logic          fifo_full;
    logic          fifo_drop;

    // Two-flop synchroniser, idle-high on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= uart_rxd;
            rxd_s <= rxd_m;
        end
    end

    // Sample and decision strobes for the current bit.
    always_comb begin
        in_bit    = (state == DATA) || (state == STOP);
        at_s0     = ((state == START) && (cnt == C_HM1)) ||
                    (in_bit && (cnt == C_E2));
        at_s1     = ((state == START) && (cnt == C_H)) ||
                    (in_bit && (cnt == C_E1));
        at_dec    = ((state == START) && (cnt == C_HP1)) ||
                    (in_bit && (cnt == C_E0));
        maj       = maj3(s0, s1, rxd_s);
        push_byte = (state == STOP) && at_dec && maj;
        stop_bad  = (state == STOP) && at_dec && !maj;
    end

    // Hold the first two of the three votes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0 <= 1'b1;
            s1 <= 1'b1;
        end else begin
            if (at_s0) s0 <= rxd_s;
            if (at_s1) s1 <= rxd_s;
        end
    end

    // Framing FSM with bit counter and LSB-first shift register.
    // WAIT_IDLE needs a short run of high samples so that a reset
    // released mid-frame cannot lock onto a data bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= WAIT_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            unique case (state)
                WAIT_IDLE: begin
                    if (!rxd_s) begin
                        cnt <= '0;
                    end else if (cnt == C_SETTLE) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE: begin
                    cnt <= '0;
                    if (!rxd_s) begin
                        state <= START;
                    end
                end
                START: begin
                    if (at_dec) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= maj ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (at_dec) begin
                        cnt   <= '0;
                        shreg <= {maj, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (at_dec) begin
                        cnt   <= '0;
                        state <= maj ? IDLE : WAIT_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= WAIT_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Sticky error flags; a new error beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad  | (frame_err & ~err_clr);
            overrun   <= fifo_drop | (overrun & ~err_clr);
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_byte),
        .wdata   (shreg),
        .pop     (rx_ready),
        .rdata   (rx_data),
        .valid   (rx_valid),
        .count   (rx_count),
        .full    (fifo_full),
        .dropped (fifo_drop)
    );

endmodule
